// File: rtl/temp_meas_sched.sv
// Burst scheduler and averager for the temperature-oscillator measurer:
// periodic/one-shot triggering, done-handshake supervision with timeout, windowed average.
module temp_meas_sched #(
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned TMO      = 15
) (
    input  logic                lfClk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic                oneshot,
    input  logic [WIDTH-1:0]    thr_lo,
    input  logic [WIDTH-1:0]    thr_hi,
    output logic                meas_start,
    input  logic                meas_done,
    input  logic [WIDTH-1:0]    meas_cycles,
    output logic [WIDTH-1:0]    avg,
    output logic                avg_valid,
    output logic                busy,
    output logic                out_of_range,
    output logic                tmo_err
);

    localparam int unsigned ACC_W = WIDTH + AVG_LOG2;
    localparam int unsigned CNT_W = AVG_LOG2 + 1;
    localparam int unsigned PH_W  = $clog2(TMO + 1);
    localparam logic [CNT_W-1:0] NSAMP   = CNT_W'(1) << AVG_LOG2;
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_ACCUM
    } state_t;

    state_t              state_q;
    logic [PERIOD_W-1:0] timer_q;
    logic [PH_W-1:0]     phase_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ACC_W-1:0]    acc_q;
    logic                pending_q;
    logic                meas_start_q;
    logic [WIDTH-1:0]    avg_q;
    logic                avg_valid_q;
    logic                oor_q;
    logic                tmo_err_q;

    logic [PERIOD_W-1:0] per_m1;
    logic                trig;
    logic [ACC_W-1:0]    acc_d;
    logic [CNT_W-1:0]    cnt_d;
    logic [WIDTH-1:0]    avg_d;

    always_comb begin
        per_m1 = (period == '0) ? '0 : period - PERIOD_W'(1);
        trig   = (enable && (timer_q == per_m1)) || pending_q;
        acc_d  = acc_q + ACC_W'(meas_cycles);
        cnt_d  = cnt_q + CNT_W'(1);
        // Top WIDTH bits of the accumulator == acc >> AVG_LOG2 (truncating).
        avg_d  = acc_d[ACC_W-1 -: WIDTH];
    end

    always_ff @(posedge lfClk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            phase_q      <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            pending_q    <= 1'b0;
            meas_start_q <= 1'b0;
            avg_q        <= '0;
            avg_valid_q  <= 1'b0;
            oor_q        <= 1'b0;
            tmo_err_q    <= 1'b0;
        end else begin
            meas_start_q <= 1'b0;
            avg_valid_q  <= 1'b0;
            if (oneshot) pending_q <= 1'b1;

            unique case (state_q)
                S_IDLE: begin
                    if (trig) begin
                        // Clearing pending here also absorbs a same-cycle oneshot.
                        timer_q      <= '0;
                        cnt_q        <= '0;
                        acc_q        <= '0;
                        pending_q    <= 1'b0;
                        meas_start_q <= 1'b1;
                        state_q      <= S_START;
                    end else if (enable) begin
                        timer_q <= timer_q + PERIOD_W'(1);
                    end else begin
                        timer_q <= '0;
                    end
                end
                S_START: begin
                    phase_q <= '0;
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!meas_done) begin
                        phase_q <= '0;
                        state_q <= S_WAIT_DONE;
                    end else if (phase_q == PH_LAST) begin
                        tmo_err_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        phase_q <= phase_q + PH_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (meas_done) begin
                        phase_q <= '0;
                        state_q <= S_ACCUM;
                    end else if (phase_q == PH_LAST) begin
                        tmo_err_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        phase_q <= phase_q + PH_W'(1);
                    end
                end
                S_ACCUM: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_d;
                    if (cnt_d == NSAMP) begin
                        avg_q       <= avg_d;
                        avg_valid_q <= 1'b1;
                        oor_q       <= (avg_d < thr_lo) || (avg_d > thr_hi);
                        state_q     <= S_IDLE;
                    end else begin
                        meas_start_q <= 1'b1;
                        state_q      <= S_START;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign meas_start   = meas_start_q;
    assign avg          = avg_q;
    assign avg_valid    = avg_valid_q;
    assign busy         = (state_q != S_IDLE);
    assign out_of_range = oor_q;
    assign tmo_err      = tmo_err_q;

endmodule

// File: doc/temp_meas_sched.md
# temp_meas_sched

Scheduler and averager for the temperature-oscillator measurement block. It issues `start` pulses to the measurer either periodically or on a one-shot request, and runs one burst of 2^AVG_LOG2 measurements per trigger. It supervises the measurer's `done` handshake with a timeout, accumulates the captured cycle counts and publishes a truncated average. It also flags results that fall outside a programmable window. It sits between the register/IRQ layer and the measurer, in the lfClk (32.768 kHz) domain.

## Interface
- WIDTH, 10: measurer cycle-count width.
- AVG_LOG2, 2: log2 of samples per burst (0..4).
- PERIOD_W, 16: interval-timer width.
- TMO, 15: max lfClk cycles spent waiting in any handshake phase.
- lfClk  in  1  lfClk domain clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  periodic mode on.
- period  in  PERIOD_W  idle lfClk cycles between bursts; 0 treated as 1.
- oneshot  in  1  single-cycle pulse requesting one burst.
- thr_lo, thr_hi  in  WIDTH  window limits for `avg`.
- meas_start  out  1  start pulse to the measurer.
- meas_done  in  1  measurer done (high = idle/result ready).
- meas_cycles  in  WIDTH  measurer result.
- avg  out  WIDTH  last burst average.
- avg_valid  out  1  one-cycle pulse when `avg` updates.
- busy  out  1  burst in progress.
- out_of_range  out  1  level: last `avg` < thr_lo or > thr_hi.
- tmo_err  out  1  sticky: handshake timeout; cleared only by reset.

## Operation
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, ACCUM.
- IDLE: the interval timer counts while `enable`=1 and holds at 0 while `enable`=0.
  - Trigger when timer == max(period,1)-1, or when `pending` is set.
  - On trigger: timer cleared, sample counter and accumulator cleared, go to START.
- `oneshot` sets the `pending` flag in any state; the flag is cleared when a burst starts. A oneshot during a busy burst produces exactly one further burst; further oneshots do not queue.
- START: `meas_start`=1 for exactly this cycle; go to WAIT_BUSY.
- WAIT_BUSY: wait for `meas_done`=0 (measurer accepted), then go to WAIT_DONE.
- WAIT_DONE: wait for `meas_done`=1, then go to ACCUM.
- ACCUM:
  - acc += meas_cycles. acc width = WIDTH+AVG_LOG2, so it cannot overflow.
  - Increment the sample counter.
  - If the counter has reached 2^AVG_LOG2: avg <= acc_new >> AVG_LOG2 (truncating), pulse `avg_valid`, update `out_of_range`, go to IDLE.
  - Otherwise go to START.
- Timeout: a phase counter resets on each state entry. If WAIT_BUSY or WAIT_DONE lasts TMO cycles:
  - set `tmo_err`;
  - abort the burst to IDLE;
  - leave `avg` unchanged and do not pulse `avg_valid`.
- `busy` = (state != IDLE).
- Window compare is inclusive-OK: thr_lo <= avg <= thr_hi means `out_of_range`=0. If thr_lo > thr_hi, every value is out of range.
- Deasserting `enable` mid-burst does not abort the burst; it only stops future periodic triggers.
- Reset values: state IDLE, meas_start 0, avg 0, avg_valid 0, busy 0, out_of_range 0, tmo_err 0, pending 0, timer 0, acc 0.
- Reset mid-burst returns to IDLE on the next edge. The measurer may finish its current conversion; its result is ignored.

## Timing
- All outputs are registered except `busy`, which is decoded from state.
- Per-sample handshake against the measurer:
  - START occupies 1 cycle.
  - Measurer `done` falls 2 edges after the start edge, giving 2 cycles in WAIT_BUSY.
  - `done` rises 3 cycles later.
  - ACCUM occupies 1 cycle.
  - Total: 7 lfClk cycles per sample.
- Burst latency from trigger to `avg_valid` = 7·2^AVG_LOG2 cycles (28 at defaults).
- After a burst, the next periodic trigger occurs `period` cycles after return to IDLE.
- A `oneshot` arriving in the same cycle as a timer trigger yields one burst, not two.

## Test plan
- Periodic: enable=1, period=10; measurer model returns 100,101,102,103 → avg=101, `avg_valid` 28 cycles after trigger; next burst starts 10 cycles after IDLE re-entry.
- Averaging edge: all samples 1023 with AVG_LOG2=2 → acc=4092, avg=1023, no overflow. AVG_LOG2=0 → avg equals the single sample.
- Oneshot: enable=0, two oneshot pulses during one burst → exactly one extra burst, then `busy`=0 indefinitely.
- Timeout: measurer holds done=1 → `tmo_err`=1 after 15 cycles in WAIT_BUSY, state IDLE, avg unchanged; `tmo_err` stays set until reset.
- Window: thr_lo=200, thr_hi=300; avg=199 → out_of_range=1; avg=200 → 0; avg=301 → 1.
- Reset mid-burst: assert reset in WAIT_DONE → next edge all outputs at reset values; with enable=1, period=5, the first burst starts 5 cycles after reset release.
